uart_xmtr: RTL and testbench
============================

# uart_xmtr

Simulation-side and synthesizable UART transmitter for system-level benches: accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and serializes them as 8N1 frames onto a single line that drives the design's UART receive pin. It is the stdin-direction counterpart of the bench's UART receiver/stdout capture. It uses the same bit-clock convention: one clock, with each serial bit held for a fixed number of clock cycles.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 16: byte buffer depth; power of two, 2..256.
- STOP_BITS, 1: number of stop bits; 1 or 2.
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- enable  input  1  when low, no new frame starts; a frame in flight completes.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte; a byte transfers on an edge where tx_valid && tx_ready.
- uart_sout  output  1  serial line, idle high; connect to the design's rxd.
- busy  output  1  high while a frame is on the line (FSM not IDLE).
- frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

## Operation
- Reset values:
  - uart_sout=1, tx_ready=1, busy=0, frame_done=0, fifo_count=0.
  - FIFO empty; FSM in IDLE.
  - A frame in flight is aborted immediately.
- FIFO:
  - Push on tx_valid && tx_ready; pop when the FSM leaves IDLE or STOP to start a frame.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - tx_ready = (fifo_count != FIFO_DEPTH); it is combinational from the registered count, so a pop does not raise tx_ready in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY (only when configured), STOP.
  - IDLE -> START: when enable && fifo_count>0; pops the byte into an 8-bit shift register.
  - START -> DATA: after CLKS_PER_BIT cycles.
  - DATA: shifts LSB first; a 3-bit index counts D0..D7, each bit held CLKS_PER_BIT cycles. Goes to PARITY or STOP after D7.
  - PARITY -> STOP: after CLKS_PER_BIT cycles.
  - STOP: held STOP_BITS*CLKS_PER_BIT cycles.
  - End of STOP: if enable && fifo_count>0, go directly to START, popping the next byte with no idle gap; otherwise go to IDLE.
- uart_sout is registered:
  - 0 in START.
  - Data bit in DATA.
  - Parity bit in PARITY.
  - 1 in STOP and IDLE.
- Bit timer: down-counter loaded with CLKS_PER_BIT-1; the bit advances when it reaches 0.
- Bytes pushed while enable is low are retained and transmitted once enable rises.

## Timing
- Push at edge k into an empty FIFO with the FSM in IDLE and enable high: FSM pops at edge k+1, and uart_sout falls after edge k+1.
- Frame length: (10 + STOP_BITS - 1 [+1 with parity]) * CLKS_PER_BIT cycles.
- Default frame (CLKS_PER_BIT=16, 1 stop bit, no parity): 160 cycles.
- frame_done is asserted in the final cycle of STOP. In a back-to-back frame, the next start bit begins on the following edge.
- busy rises with the start bit and falls on the edge that returns the FSM to IDLE.
- Reset asserted mid-frame: uart_sout=1 immediately, without waiting for a clock edge. The partial frame is never resumed.

## Configuration
- UART_XMTR_PARITY_EN defined:
  - PARITY state inserted between D7 and STOP.
  - Transmitted bit is even parity, the XOR of the 8 data bits.
  - Frame grows by CLKS_PER_BIT cycles.
- UART_XMTR_PARITY_EN undefined:
  - No PARITY state or logic; plain 8N1 (or 8N2) framing.

## Test plan
- Single byte, CLKS_PER_BIT=4, no parity:
  - Stimulus: push 0x55.
  - Required: uart_sout falls 1 cycle after accept, then 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total).
  - Required: frame_done pulses once; busy high for exactly 40 cycles.
- Parity build, CLKS_PER_BIT=4:
  - Stimulus: push 0x07.
  - Required: data bits 1,1,1,0,0,0,0,0, then parity bit 1, then stop; 44 cycles total.
  - Stimulus: push 0x03.
  - Required: parity bit 0.
- Back-to-back:
  - Stimulus: push 0xA5, 0x3C, 0xFF on consecutive cycles.
  - Required: three contiguous frames with no idle cycle between stop and start; fifo_count goes 1,1,2,...,0.
- Full FIFO, FIFO_DEPTH=4, enable=0:
  - Stimulus: push 5 bytes with tx_valid held high.
  - Required: after the 4th push tx_ready=0, the 5th byte is not accepted, and fifo_count=4.
  - Stimulus: raise enable.
  - Required: tx_ready returns 1 on the cycle after the first pop.
- Reset mid-frame:
  - Stimulus: assert reset during D3 of 0x81 with 2 bytes queued.
  - Required: uart_sout=1 with no clock edge needed; fifo_count=0; no frame after release until a new push.
- Enable gating:
  - Stimulus: drop enable during D5.
  - Required: the current frame completes with correct stop bit(s); the queued byte starts only after enable returns high.

Source files
------------

// File: rtl/uart_xmtr.sv
// uart_xmtr: valid/ready byte input, FIFO buffer, 8N1/8N2 serializer.
// Optional even-parity bit between D7 and the stop bit(s) when the
// UART_XMTR_PARITY_EN macro is defined; default build has no parity.
module uart_xmtr #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_sout,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int CW        = PW + 1;
    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    // Timer is shared by all states, so it is sized for the longest hold (stop).
    localparam int TW        = $clog2(STOP_CLKS);

    localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LOAD = TW'(STOP_CLKS - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_XMTR_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            sout_q, sout_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef UART_XMTR_PARITY_EN
    logic            par_q, par_d;
`endif

    logic            push;
    logic            pop;
    logic            start_ok;
    logic            bit_end;
    logic [7:0]      rd_data;

    assign tx_ready   = (count_q != FULL);
    assign push       = tx_valid && tx_ready;
    assign start_ok   = enable && (count_q != '0);
    assign bit_end    = (timer_q == '0);
    assign rd_data    = mem_q[rd_ptr_q];
    assign uart_sout  = sout_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP) && bit_end;
    assign fifo_count = count_q;

    // FIFO storage: no reset needed, validity is tracked by count/pointers.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Frame FSM: next state, bit timer, shifter and registered line value.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        sout_d    = sout_q;
        pop       = 1'b0;
`ifdef UART_XMTR_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                sout_d = 1'b1;
                if (start_ok) begin
                    state_d = S_START;
                    pop     = 1'b1;
                    shift_d = rd_data;
                    timer_d = BIT_LOAD;
                    sout_d  = 1'b0;
`ifdef UART_XMTR_PARITY_EN
                    par_d   = ^rd_data;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    timer_d   = BIT_LOAD;
                    bit_idx_d = 3'd0;
                    sout_d    = shift_q[0];
                    shift_d   = shift_q >> 1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_XMTR_PARITY_EN
                        state_d = S_PARITY;
                        timer_d = BIT_LOAD;
                        sout_d  = par_q;
`else
                        state_d = S_STOP;
                        timer_d = STOP_LOAD;
                        sout_d  = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        timer_d   = BIT_LOAD;
                        sout_d    = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`ifdef UART_XMTR_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    timer_d = STOP_LOAD;
                    sout_d  = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (start_ok) begin
                        state_d = S_START;
                        pop     = 1'b1;
                        shift_d = rd_data;
                        timer_d = BIT_LOAD;
                        sout_d  = 1'b0;
`ifdef UART_XMTR_PARITY_EN
                        par_d   = ^rd_data;
`endif
                    end else begin
                        state_d = S_IDLE;
                        sout_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                sout_d  = 1'b1;
            end
        endcase
    end

    // State register; async reset forces the line high without a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            sout_q    <= 1'b1;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
`ifdef UART_XMTR_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            sout_q    <= sout_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
`ifdef UART_XMTR_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_xmtr.sv
// tb_uart_xmtr: directed bench for uart_xmtr with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Honors UART_XMTR_PARITY_EN for the expected frame shape.
module tb_uart_xmtr;

    localparam int C  = 4;
`ifdef UART_XMTR_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = (10 + PAR) * C;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       uart_sout;
    logic       busy;
    logic       frame_done;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;

    uart_xmtr #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_sout  (uart_sout),
        .busy       (busy),
        .frame_done (frame_done),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected line value c cycles after the start bit began.
    function automatic logic exp_bit(input logic [7:0] b, input int c);
        int j;
        j = c / C;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (PAR == 1 && j == 9) return ^b;
        return 1'b1;
    endfunction

    // Walk a frame from cycle c0 to its end, checking line, busy and frame_done.
    task automatic check_frame(input string tag, input logic [7:0] b, input int c0);
        for (int c = c0; c < FL; c++) begin
            chk({tag, ".sout"}, uart_sout, exp_bit(b, c));
            chk({tag, ".busy"}, busy, 1'b1);
            chk({tag, ".done"}, frame_done, (c == FL - 1));
            tick();
        end
    endtask

    task automatic push1(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    initial begin
        int lows;

        // Reset state
        #1 reset = 1'b1;
        #2;
        chk("rst.sout", uart_sout, 1'b1);
        chk("rst.ready", tx_ready, 1'b1);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", frame_done, 1'b0);
        chk("rst.count", fifo_count, 3'd0);
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b0;
        enable = 1'b1;
        tick();

        // Single byte 0x55
        push1(8'h55);
        chk("b55.pre_sout", uart_sout, 1'b1);
        chk("b55.count", fifo_count, 3'd1);
        chk("b55.pre_busy", busy, 1'b0);
        tick();
        check_frame("b55", 8'h55, 0);
        chk("b55.post_busy", busy, 1'b0);
        chk("b55.post_sout", uart_sout, 1'b1);
        chk("b55.post_count", fifo_count, 3'd0);

        // Parity-sensitive bytes
        push1(8'h07);
        tick();
        check_frame("b07", 8'h07, 0);
        push1(8'h03);
        tick();
        check_frame("b03", 8'h03, 0);
        chk("b03.post_busy", busy, 1'b0);

        // Back-to-back
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        chk("b2b.cnt1", fifo_count, 3'd1);
        tx_data = 8'h3C;
        tick();
        chk("b2b.cnt2", fifo_count, 3'd1);
        chk("b2b.start", uart_sout, 1'b0);
        tx_data = 8'hFF;
        tick();
        tx_valid = 1'b0;
        chk("b2b.cnt3", fifo_count, 3'd2);
        check_frame("b2b.A5", 8'hA5, 1);
        chk("b2b.cnt4", fifo_count, 3'd1);
        check_frame("b2b.3C", 8'h3C, 0);
        chk("b2b.cnt5", fifo_count, 3'd0);
        check_frame("b2b.FF", 8'hFF, 0);
        chk("b2b.end_busy", busy, 1'b0);
        chk("b2b.end_sout", uart_sout, 1'b1);

        // Full FIFO with enable low
        enable   = 1'b0;
        tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_data = 8'h10 + 8'(i);
            tick();
            chk("full.count", fifo_count, (i < 4) ? 3'(i + 1) : 3'd4);
            chk("full.ready", tx_ready, (i < 3));
        end
        tx_valid = 1'b0;
        chk("full.busy", busy, 1'b0);
        enable = 1'b1;
        tick();
        chk("full.pop_count", fifo_count, 3'd3);
        chk("full.pop_ready", tx_ready, 1'b1);
        check_frame("full.10", 8'h10, 0);
        check_frame("full.11", 8'h11, 0);
        check_frame("full.12", 8'h12, 0);
        check_frame("full.13", 8'h13, 0);
        chk("full.end_busy", busy, 1'b0);
        chk("full.end_count", fifo_count, 3'd0);

        // Enable gating: drop enable during D5
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        tick();
        tx_data = 8'h5A;
        tick();
        tx_valid = 1'b0;
        for (int c = 0; c < 25; c++) tick();
        enable = 1'b0;
        check_frame("gate.C3", 8'hC3, 25);
        chk("gate.idle_busy", busy, 1'b0);
        chk("gate.held_count", fifo_count, 3'd1);
        lows = 0;
        for (int c = 0; c < 10; c++) begin
            if (uart_sout !== 1'b1 || busy !== 1'b0) lows++;
            tick();
        end
        chk("gate.no_start", lows, 0);
        enable = 1'b1;
        tick();
        chk("gate.pop_count", fifo_count, 3'd0);
        check_frame("gate.5A", 8'h5A, 0);

        // Reset mid-frame during D3 of 0x81
        tx_valid = 1'b1;
        tx_data  = 8'h81;
        tick();
        tx_data = 8'h11;
        tick();
        tx_data = 8'h22;
        tick();
        tx_valid = 1'b0;
        for (int c = 1; c < 17; c++) tick();
        chk("rmid.d3", uart_sout, 1'b0);
        chk("rmid.queued", fifo_count, 3'd2);
        #2 reset = 1'b1;
        #1;
        chk("rmid.sout", uart_sout, 1'b1);
        chk("rmid.count", fifo_count, 3'd0);
        chk("rmid.busy", busy, 1'b0);
        #2 reset = 1'b0;
        lows = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (uart_sout !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("rmid.no_resume", lows, 0);
        chk("rmid.end_count", fifo_count, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
